// File: rtl/friscv_pkg.sv
// Shared configuration for the writeback path.
//   ARCH          : data width of results and the register file
//   REGFILE_DEPTH : number of architectural registers
//   wb_src_e      : writeback source, also the encoding of the arbiter priority
package friscv_pkg;

    localparam int ARCH          = 32;
    localparam int REGFILE_DEPTH = 32;

    typedef enum logic {
        WB_LSU = 1'b0,
        WB_ALU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, x0 never pending.
//   clk, rst_n          : clock, synchronous active-low reset
//   set_en / set_addr   : mark a register as awaiting writeback
//   clr_en / clr_addr   : writeback completed for a register
//   rs1_addr / rs1_busy : combinational query 1
//   rs2_addr / rs2_busy : combinational query 2
module wb_scoreboard
    import friscv_pkg::*;
#(
    parameter  int REGFILE_DEPTH = friscv_pkg::REGFILE_DEPTH,
    localparam int AW            = $clog2(REGFILE_DEPTH)
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1_addr,
    output logic          rs1_busy,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs2_busy
);

    localparam logic [REGFILE_DEPTH-1:0] X0_MASK = {{(REGFILE_DEPTH-1){1'b1}}, 1'b0};

    logic [REGFILE_DEPTH-1:0] r_pending;
    logic [REGFILE_DEPTH-1:0] w_set_mask;
    logic [REGFILE_DEPTH-1:0] w_clr_mask;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (set_en) w_set_mask[set_addr] = 1'b1;
        if (clr_en) w_clr_mask[clr_addr] = 1'b1;
    end

    // Set is OR-ed in after the clear so a same-edge set/clear leaves the bit set;
    // X0_MASK keeps bit 0 at zero so an address-0 query always reads idle.
    always_ff @(posedge clk) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & X0_MASK;
    end

    assign rs1_busy = r_pending[rs1_addr];
    assign rs2_busy = r_pending[rs2_addr];

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter: merges LSU and ALU results into one register-file write
// port, one result per cycle, and tracks pending destinations for hazard checks.
//   clk, rst_n                         : clock, synchronous active-low reset
//   iss_valid / iss_rd                 : issued instruction with a destination
//   lsu_valid/lsu_rd/lsu_data/lsu_ready: load result handshake
//   alu_valid/alu_rd/alu_data/alu_ready: ALU result handshake
//   rs1_addr/rs1_busy, rs2_addr/rs2_busy: hazard queries
//   we / addr_w / data_w               : register file write port (registered)
module writeback_unit
    import friscv_pkg::*;
#(
    parameter  int ARCH          = friscv_pkg::ARCH,
    parameter  int REGFILE_DEPTH = friscv_pkg::REGFILE_DEPTH,
    localparam int AW            = $clog2(REGFILE_DEPTH)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [ARCH-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [ARCH-1:0] alu_data,
    output logic            alu_ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            we,
    output logic [AW-1:0]   addr_w,
    output logic [ARCH-1:0] data_w
);

    wb_src_e         r_prio;
    wb_src_e         w_prio_nxt;
    logic            r_we;
    logic [AW-1:0]   r_addr_w;
    logic [ARCH-1:0] r_data_w;

    always_ff @(posedge clk) begin
        if (!rst_n) r_prio <= WB_LSU;
        else        r_prio <= w_prio_nxt;
    end

    // Priority only rotates on contention; readies are held low during reset
    // so a coincident handshake is dropped.
    always_comb begin
        lsu_ready  = 1'b0;
        alu_ready  = 1'b0;
        w_prio_nxt = r_prio;
        if (rst_n) begin
            if (lsu_valid && alu_valid) begin
                if (r_prio == WB_LSU) begin
                    lsu_ready  = 1'b1;
                    w_prio_nxt = WB_ALU;
                end else begin
                    alu_ready  = 1'b1;
                    w_prio_nxt = WB_LSU;
                end
            end else begin
                lsu_ready = lsu_valid;
                alu_ready = alu_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_addr_w <= '0;
            r_data_w <= '0;
        end else if (lsu_valid && lsu_ready) begin
            r_we     <= (lsu_rd != '0);
            r_addr_w <= lsu_rd;
            r_data_w <= lsu_data;
        end else if (alu_valid && alu_ready) begin
            r_we     <= (alu_rd != '0);
            r_addr_w <= alu_rd;
            r_data_w <= alu_data;
        end else begin
            r_we     <= 1'b0;
        end
    end

    assign we     = r_we;
    assign addr_w = r_addr_w;
    assign data_w = r_data_w;

    wb_scoreboard #(
        .REGFILE_DEPTH (REGFILE_DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_valid),
        .set_addr (iss_rd),
        .clr_en   (r_we),
        .clr_addr (r_addr_w),
        .rs1_addr (rs1_addr),
        .rs1_busy (rs1_busy),
        .rs2_addr (rs2_addr),
        .rs2_busy (rs2_busy)
    );

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

    localparam int ARCH = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd;
    logic [ARCH-1:0] lsu_data;
    logic            lsu_ready;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [ARCH-1:0] alu_data;
    logic            alu_ready;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            we;
    logic [AW-1:0]   addr_w;
    logic [ARCH-1:0] data_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    writeback_unit #(
        .ARCH          (32),
        .REGFILE_DEPTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .we        (we),
        .addr_w    (addr_w),
        .data_w    (data_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; iss_valid = 1'b0; iss_rd = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        tick();
        tick();
        check("rst_we", we, 0);
        check("rst_addr_w", addr_w, 0);
        check("rst_data_w", data_w, 0);
        lsu_valid = 1'b1; alu_valid = 1'b1;
        #1;
        check("rst_lsu_ready", lsu_ready, 0);
        check("rst_alu_ready", alu_ready, 0);
        lsu_valid = 1'b0; alu_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // single ALU result
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check("single_alu_ready", alu_ready, 1);
        check("single_lsu_ready", lsu_ready, 0);
        tick();
        alu_valid = 1'b0;
        check("single_we", we, 1);
        check("single_addr_w", addr_w, 5);
        check("single_data_w", data_w, 32'hDEADBEEF);
        #1;
        check("idle_alu_ready", alu_ready, 0);
        tick();
        check("idle_we", we, 0);
        check("hold_addr_w", addr_w, 5);
        check("hold_data_w", data_w, 32'hDEADBEEF);

        // single LSU result
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h0000_0011;
        #1;
        check("single_lsu_ready2", lsu_ready, 1);
        check("single_alu_ready2", alu_ready, 0);
        tick();
        lsu_valid = 1'b0;
        check("lsu_we", we, 1);
        check("lsu_addr_w", addr_w, 8);
        check("lsu_data_w", data_w, 32'h0000_0011);

        // contention: expected grants L,A,L,A,L,A,L,A; last cycle ALU alone
        for (int i = 0; i < 8; i++) begin
            int l_idx;
            int a_idx;
            l_idx = (i + 1) / 2;
            a_idx = i / 2;
            lsu_valid = (l_idx < 4);
            alu_valid = (a_idx < 4);
            lsu_rd    = AW'(1 + l_idx);
            lsu_data  = 32'h0000_0100 + 32'(1 + l_idx);
            alu_rd    = AW'(9 + a_idx);
            alu_data  = 32'h0000_0200 + 32'(9 + a_idx);
            #1;
            check($sformatf("cont_lsu_ready_%0d", i), lsu_ready, (i % 2 == 0));
            check($sformatf("cont_alu_ready_%0d", i), alu_ready, (i % 2 == 1));
            tick();
            check($sformatf("cont_we_%0d", i), we, 1);
            if (i % 2 == 0) begin
                check($sformatf("cont_addr_%0d", i), addr_w, 1 + l_idx);
                check($sformatf("cont_data_%0d", i), data_w, 32'h100 + 1 + l_idx);
            end else begin
                check($sformatf("cont_addr_%0d", i), addr_w, 9 + a_idx);
                check($sformatf("cont_data_%0d", i), data_w, 32'h200 + 9 + a_idx);
            end
        end
        lsu_valid = 1'b0; alu_valid = 1'b0;
        tick();
        check("cont_done_we", we, 0);

        // scoreboard on x7
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        rs1_addr = 5'd7; rs2_addr = 5'd0;
        #1;
        check("sb_rs1_busy7", rs1_busy, 1);
        check("sb_rs2_busy0", rs2_busy, 0);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hCAFE0007;
        rs2_addr = 5'd7;
        #1;
        check("sb_rs2_busy7", rs2_busy, 1);
        tick();
        alu_valid = 1'b0;
        check("sb_write_we", we, 1);
        check("sb_write_addr", addr_w, 7);
        check("sb_busy_at_write", rs1_busy, 1);
        tick();
        check("sb_busy_after_write", rs1_busy, 0);
        check("sb_we_after", we, 0);

        // x0 never pending and never written
        iss_valid = 1'b1; iss_rd = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        rs1_addr = 5'd0;
        #1;
        check("x0_alu_ready", alu_ready, 1);
        tick();
        iss_valid = 1'b0; alu_valid = 1'b0;
        check("x0_we", we, 0);
        check("x0_data_w", data_w, 32'h0000_1234);
        check("x0_busy", rs1_busy, 0);
        tick();
        check("x0_busy_later", rs1_busy, 0);

        // same-edge set and clear of x3
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0333;
        tick();
        alu_valid = 1'b0;
        check("same_we", we, 1);
        check("same_addr", addr_w, 3);
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_valid = 1'b0;
        rs1_addr = 5'd3;
        #1;
        check("same_edge_busy3", rs1_busy, 1);

        // reset mid-operation with x2, x6 pending and prio left at ALU
        iss_valid = 1'b1; iss_rd = 5'd2;
        tick();
        iss_rd = 5'd6;
        tick();
        iss_valid = 1'b0;
        rs1_addr = 5'd2; rs2_addr = 5'd6;
        #1;
        check("pre_rst_busy2", rs1_busy, 1);
        check("pre_rst_busy6", rs2_busy, 1);
        lsu_valid = 1'b1; lsu_rd = 5'd22; lsu_data = 32'h0000_0022;
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h0000_0021;
        #1;
        check("prio_kept_alu", alu_ready, 1);
        check("prio_kept_lsu", lsu_ready, 0);
        tick();
        alu_rd = 5'd23; alu_data = 32'h0000_0023;
        #1;
        check("prio_then_lsu", lsu_ready, 1);
        tick();
        lsu_rd = 5'd24; lsu_data = 32'h0000_0024;
        rst_n = 1'b0;
        #1;
        check("rst_hs_lsu_ready", lsu_ready, 0);
        check("rst_hs_alu_ready", alu_ready, 0);
        tick();
        rst_n = 1'b1;
        check("post_rst_we", we, 0);
        check("post_rst_data_w", data_w, 0);
        check("post_rst_busy2", rs1_busy, 0);
        check("post_rst_busy6", rs2_busy, 0);
        rs1_addr = 5'd3;
        #1;
        check("post_rst_busy3", rs1_busy, 0);
        check("post_rst_prio_lsu", lsu_ready, 1);
        check("post_rst_prio_alu", alu_ready, 0);
        tick();
        check("re_lsu_we", we, 1);
        check("re_lsu_addr", addr_w, 24);
        lsu_valid = 1'b0;
        #1;
        check("re_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        check("re_alu_addr", addr_w, 23);
        check("re_alu_data", data_w, 32'h0000_0023);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
